// File: rtl/mont_cmd_responder_if.sv
// Host-side bus of the Montgomery command responder: the command port, the
// completion port and both BRAM streams travel together in this bundle.
interface mont_cmd_responder_if #(
  parameter int WORD_LEN = 512
);
  logic [31:0]         port1_din;
  logic                port1_valid;
  logic                port1_read;
  logic                port2_valid;
  logic                port2_read;
  logic [WORD_LEN-1:0] bram_din;
  logic                bram_din_valid;
  logic [WORD_LEN-1:0] bram_dout;
  logic                bram_dout_valid;
  logic                bram_dout_read;

  // Host / DMA view: issues commands, supplies operands, consumes results.
  modport master (
    output port1_din, port1_valid, port2_read,
    output bram_din, bram_din_valid, bram_dout_read,
    input  port1_read, port2_valid, bram_dout, bram_dout_valid
  );

  // Responder view.
  modport slave (
    input  port1_din, port1_valid, port2_read,
    input  bram_din, bram_din_valid, bram_dout_read,
    output port1_read, port2_valid, bram_dout, bram_dout_valid
  );
endinterface

// File: rtl/mont_cmd_responder.sv
// Command-side responder for one external Montgomery multiplier core.
// Decodes 3-bit opcodes from the host, loads A/B/M from the BRAM input
// stream, kicks the core, returns its result on the BRAM output stream and
// reports completion of every command on port2. All outputs are registered
// and change together with the state register.
module mont_cmd_responder #(
  parameter int WORD_LEN = 512
) (
  input  logic                clk,
  input  logic                reset,
  mont_cmd_responder_if.slave host,
  output logic [WORD_LEN-1:0] mult_a,
  output logic [WORD_LEN-1:0] mult_b,
  output logic [WORD_LEN-1:0] mult_m,
  output logic                mult_start,
  input  logic                mult_done,
  input  logic [WORD_LEN-1:0] mult_result,
  output logic [3:0]          leds
);

  // Encoding is visible on leds[2:0], so the values are fixed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    BUSY   = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [2:0] OP_READ_A   = 3'd0;
  localparam logic [2:0] OP_READ_B   = 3'd1;
  localparam logic [2:0] OP_READ_M   = 3'd2;
  localparam logic [2:0] OP_MULTIPLY = 3'd3;
  localparam logic [2:0] OP_WRITE    = 3'd4;

  state_t              state_q, state_d;
  logic [2:0]          opcode_q, opcode_d;
  logic                err_q, err_d;
  logic                port1_read_q, port1_read_d;
  logic                port2_valid_q, port2_valid_d;
  logic                bram_dout_valid_q, bram_dout_valid_d;
  logic                mult_start_q, mult_start_d;
  logic [WORD_LEN-1:0] a_q, a_d;
  logic [WORD_LEN-1:0] b_q, b_d;
  logic [WORD_LEN-1:0] m_q, m_d;
  logic [WORD_LEN-1:0] result_q, result_d;

  // Only the low three command bits carry meaning; the rest are ignored.
  logic cmd_unused;
  assign cmd_unused = ^host.port1_din[31:3];

  // Next-state and next-output logic; every output is computed here so it
  // lands in a flop alongside the state it belongs to.
  always_comb begin
    state_d           = state_q;
    opcode_d          = opcode_q;
    err_d             = err_q;
    port1_read_d      = port1_read_q;
    port2_valid_d     = port2_valid_q;
    bram_dout_valid_d = bram_dout_valid_q;
    mult_start_d      = mult_start_q;
    a_d               = a_q;
    b_d               = b_q;
    m_d               = m_q;
    result_d          = result_q;

    case (state_q)
      IDLE: begin
        if (host.port1_valid) begin
          opcode_d     = host.port1_din[2:0];
          port1_read_d = 1'b1;
          state_d      = ACCEPT;
        end
      end

      ACCEPT: begin
        port1_read_d = 1'b0;
        err_d        = 1'b0;
        case (opcode_q)
          OP_READ_A, OP_READ_B, OP_READ_M: state_d = LOAD;
          OP_MULTIPLY: begin
            mult_start_d = 1'b1;
            state_d      = START;
          end
          OP_WRITE: begin
            bram_dout_valid_d = 1'b1;
            state_d           = WRITE;
          end
          default: begin
            err_d         = 1'b1;
            port2_valid_d = 1'b1;
            state_d       = DONE;
          end
        endcase
      end

      LOAD: begin
        if (host.bram_din_valid) begin
          case (opcode_q)
            OP_READ_A: a_d = host.bram_din;
            OP_READ_B: b_d = host.bram_din;
            default:   m_d = host.bram_din;
          endcase
          port2_valid_d = 1'b1;
          state_d       = DONE;
        end
      end

      START: begin
        mult_start_d = 1'b0;
        state_d      = BUSY;
      end

      BUSY: begin
        if (mult_done) begin
          result_d      = mult_result;
          port2_valid_d = 1'b1;
          state_d       = DONE;
        end
      end

      WRITE: begin
        if (host.bram_dout_read) begin
          bram_dout_valid_d = 1'b0;
          port2_valid_d     = 1'b1;
          state_d           = DONE;
        end
      end

      DONE: begin
        if (host.port2_read) begin
          port2_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, operand and output registers; reset abandons any core run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      opcode_q          <= 3'd0;
      err_q             <= 1'b0;
      port1_read_q      <= 1'b0;
      port2_valid_q     <= 1'b0;
      bram_dout_valid_q <= 1'b0;
      mult_start_q      <= 1'b0;
      a_q               <= '0;
      b_q               <= '0;
      m_q               <= '0;
      result_q          <= '0;
    end else begin
      state_q           <= state_d;
      opcode_q          <= opcode_d;
      err_q             <= err_d;
      port1_read_q      <= port1_read_d;
      port2_valid_q     <= port2_valid_d;
      bram_dout_valid_q <= bram_dout_valid_d;
      mult_start_q      <= mult_start_d;
      a_q               <= a_d;
      b_q               <= b_d;
      m_q               <= m_d;
      result_q          <= result_d;
    end
  end

  assign host.port1_read      = port1_read_q;
  assign host.port2_valid     = port2_valid_q;
  assign host.bram_dout       = result_q;
  assign host.bram_dout_valid = bram_dout_valid_q;
  assign mult_a               = a_q;
  assign mult_b               = b_q;
  assign mult_m               = m_q;
  assign mult_start           = mult_start_q;
  assign leds                 = {err_q, state_q};

endmodule

// File: tb/tb_mont_cmd_responder.sv
// Directed bench for mont_cmd_responder. Inputs are driven and outputs
// sampled on the falling clock edge; the multiplier core is modelled inline.
module tb_mont_cmd_responder;
  localparam int WL = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WL-1:0] mult_a, mult_b, mult_m, mult_result;
  logic          mult_start, mult_done;
  logic [3:0]    leds;
  int            checks = 0;
  int            errors = 0;

  mont_cmd_responder_if #(.WORD_LEN(WL)) bus ();

  mont_cmd_responder #(.WORD_LEN(WL)) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (bus),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_m     (mult_m),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .mult_result(mult_result),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  // Present a command and wait (bounded) for the accept pulse, then drop it.
  task automatic send_cmd(input logic [31:0] word, output logic ok);
    ok = 1'b0;
    bus.port1_din   = word;
    bus.port1_valid = 1'b1;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (bus.port1_read === 1'b1) ok = 1'b1;
    end
    bus.port1_valid = 1'b0;
  endtask

  // Wait (bounded) for completion and acknowledge it.
  task automatic ack_done(output logic ok);
    for (int i = 0; i < 20 && bus.port2_valid !== 1'b1; i++) @(negedge clk);
    ok = (bus.port2_valid === 1'b1);
    bus.port2_read = 1'b1;
    @(negedge clk);
    bus.port2_read = 1'b0;
  endtask

  // Complete load command with the word held valid until completion.
  task automatic do_load(input logic [2:0] op, input logic [WL-1:0] data, output logic ok);
    logic ok1, ok2;
    send_cmd({29'd0, op}, ok1);
    bus.bram_din       = data;
    bus.bram_din_valid = 1'b1;
    for (int i = 0; i < 5 && bus.port2_valid !== 1'b1; i++) @(negedge clk);
    bus.bram_din_valid = 1'b0;
    ack_done(ok2);
    ok = ok1 & ok2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (leds !== 4'h0) begin errors++; $display("[TB] FAIL reset_leds: got %0h expected 0", leds); end
    checks++;
    if ({bus.port1_read, bus.port2_valid, bus.bram_dout_valid, mult_start} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000",
                         {bus.port1_read, bus.port2_valid, bus.bram_dout_valid, mult_start});
    end
    checks++;
    if ((mult_a | mult_b | mult_m | bus.bram_dout) !== '0) begin
      errors++; $display("[TB] FAIL reset_words: got %0h expected 0", mult_a | mult_b | mult_m | bus.bram_dout);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_zero();
    logic ok;
    send_cmd(32'd4, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL wz_accept: got %b expected 1", ok); end
    @(negedge clk);
    checks++;
    if (bus.bram_dout_valid !== 1'b1 || bus.bram_dout !== '0) begin
      errors++; $display("[TB] FAIL wz_data: got valid %b data %0h expected valid 1 data 0",
                         bus.bram_dout_valid, bus.bram_dout);
    end
    bus.bram_dout_read = 1'b1;
    @(negedge clk);
    bus.bram_dout_read = 1'b0;
    ack_done(ok);
  endtask

  task automatic test_load_a();
    logic ok;
    send_cmd(32'd0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL cmd0_accept: got %b expected 1", ok); end
    @(negedge clk);
    checks++;
    if (bus.port1_read !== 1'b0) begin errors++; $display("[TB] FAIL cmd0_read_pulse: got %b expected 0", bus.port1_read); end
    checks++;
    if (leds !== 4'h2) begin errors++; $display("[TB] FAIL load_state: got %0h expected 2", leds); end
    bus.bram_din       = 512'h5;
    bus.bram_din_valid = 1'b1;
    @(negedge clk);
    bus.bram_din_valid = 1'b0;
    bus.bram_din       = '0;
    checks++;
    if (bus.port2_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_a_done: got %b expected 1", bus.port2_valid); end
    checks++;
    if (mult_a !== 512'h5) begin errors++; $display("[TB] FAIL load_a_value: got %0h expected 5", mult_a); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.port2_valid !== 1'b1) begin errors++; $display("[TB] FAIL port2_held: got %b expected 1", bus.port2_valid); end
    bus.port2_read = 1'b1;
    @(negedge clk);
    bus.port2_read = 1'b0;
    checks++;
    if (bus.port2_valid !== 1'b0 || leds !== 4'h0) begin
      errors++; $display("[TB] FAIL port2_clear: got valid %b leds %0h expected valid 0 leds 0", bus.port2_valid, leds);
    end
  endtask

  task automatic test_multiply();
    logic ok_b, ok_m, ok;
    int   starts;
    do_load(3'd1, 512'h7, ok_b);
    do_load(3'd2, 512'hB, ok_m);
    checks++;
    if (mult_b !== 512'h7 || mult_m !== 512'hB || !(ok_b && ok_m)) begin
      errors++; $display("[TB] FAIL load_bm: got b %0h m %0h expected b 7 m b", mult_b, mult_m);
    end
    send_cmd(32'd3, ok);
    starts = (mult_start === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mult_start === 1'b1) starts++;
    end
    checks++;
    if (bus.port2_valid !== 1'b0 || leds !== 4'h4) begin
      errors++; $display("[TB] FAIL busy_wait: got valid %b leds %0h expected valid 0 leds 4", bus.port2_valid, leds);
    end
    mult_result = 512'h9;
    mult_done   = 1'b1;
    @(negedge clk);
    mult_done   = 1'b0;
    mult_result = '0;
    checks++;
    if (bus.port2_valid !== 1'b1) begin errors++; $display("[TB] FAIL mult_done: got %b expected 1", bus.port2_valid); end
    checks++;
    if (starts !== 1 || ok !== 1'b1) begin errors++; $display("[TB] FAIL start_pulses: got %0d expected 1", starts); end
    checks++;
    if (mult_a !== 512'h5) begin errors++; $display("[TB] FAIL a_stable: got %0h expected 5", mult_a); end
    ack_done(ok);
  endtask

  task automatic test_write();
    logic ok, held;
    send_cmd(32'd4, ok);
    @(negedge clk);
    checks++;
    if (bus.bram_dout_valid !== 1'b1 || bus.bram_dout !== 512'h9) begin
      errors++; $display("[TB] FAIL write_data: got valid %b data %0h expected valid 1 data 9",
                         bus.bram_dout_valid, bus.bram_dout);
    end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.bram_dout_valid !== 1'b1 || bus.bram_dout !== 512'h9 || bus.port2_valid !== 1'b0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin errors++; $display("[TB] FAIL write_hold: got %b expected 1", held); end
    bus.bram_dout_read = 1'b1;
    @(negedge clk);
    bus.bram_dout_read = 1'b0;
    checks++;
    if (bus.port2_valid !== 1'b1 || bus.bram_dout_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL write_done: got p2 %b dv %b expected p2 1 dv 0", bus.port2_valid, bus.bram_dout_valid);
    end
    ack_done(ok);
  endtask

  task automatic test_illegal();
    logic ok;
    send_cmd(32'd7, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL ill_accept: got %b expected 1", ok); end
    @(negedge clk);
    checks++;
    if (leds !== 4'hE || bus.port2_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL ill_done: got leds %0h p2 %b expected leds e p2 1", leds, bus.port2_valid);
    end
    ack_done(ok);
    checks++;
    if (leds !== 4'h8) begin errors++; $display("[TB] FAIL err_held: got %0h expected 8", leds); end
    send_cmd(32'd0, ok);
    @(negedge clk);
    checks++;
    if (leds !== 4'h2) begin errors++; $display("[TB] FAIL err_clear: got %0h expected 2", leds); end
    bus.bram_din       = 512'h5;
    bus.bram_din_valid = 1'b1;
    @(negedge clk);
    bus.bram_din_valid = 1'b0;
    ack_done(ok);
  endtask

  task automatic test_drop();
    logic ok;
    bus.bram_din       = 512'hAA;
    bus.bram_din_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.bram_din_valid = 1'b0;
    checks++;
    if (mult_a !== 512'h5) begin errors++; $display("[TB] FAIL idle_word_dropped: got %0h expected 5", mult_a); end
    bus.bram_din       = 512'h3;
    bus.bram_din_valid = 1'b1;
    send_cmd(32'd0, ok);
    @(negedge clk);
    checks++;
    if (bus.port2_valid !== 1'b0 || leds !== 4'h2) begin
      errors++; $display("[TB] FAIL latency_early: got p2 %b leds %0h expected p2 0 leds 2", bus.port2_valid, leds);
    end
    @(negedge clk);
    bus.bram_din_valid = 1'b0;
    checks++;
    if (bus.port2_valid !== 1'b1 || mult_a !== 512'h3) begin
      errors++; $display("[TB] FAIL min_latency: got p2 %b a %0h expected p2 1 a 3", bus.port2_valid, mult_a);
    end
    ack_done(ok);
  endtask

  task automatic test_reset_busy();
    logic ok;
    send_cmd(32'd3, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== 4'h4) begin errors++; $display("[TB] FAIL rb_busy: got %0h expected 4", leds); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (leds !== 4'h0 || mult_a !== '0 || mult_b !== '0 || mult_m !== '0 || bus.bram_dout !== '0) begin
      errors++; $display("[TB] FAIL rb_async: got leds %0h a %0h b %0h expected all 0", leds, mult_a, mult_b);
    end
    @(negedge clk);
    reset       = 1'b0;
    mult_result = 512'h55;
    mult_done   = 1'b1;
    @(negedge clk);
    mult_done   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== 4'h0 || bus.port2_valid !== 1'b0 || bus.bram_dout !== '0) begin
      errors++; $display("[TB] FAIL rb_late_done: got leds %0h p2 %b dout %0h expected 0 0 0",
                         leds, bus.port2_valid, bus.bram_dout);
    end
  endtask

  initial begin
    bus.port1_din      = '0;
    bus.port1_valid    = 1'b0;
    bus.port2_read     = 1'b0;
    bus.bram_din       = '0;
    bus.bram_din_valid = 1'b0;
    bus.bram_dout_read = 1'b0;
    mult_done          = 1'b0;
    mult_result        = '0;
    test_reset();
    test_write_zero();
    test_load_a();
    test_multiply();
    test_write();
    test_illegal();
    test_drop();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mont_cmd_responder.md
Name: mont_cmd_responder

Overview:
- Command-side responder for a single Montgomery multiplier core.
- Accepts 32-bit commands from the host on port1 and loads A/B/M operands from the BRAM input stream.
- Starts the multiplier, returns the result on the BRAM output stream, and signals completion of each command on port2.
- Sits between the host/DMA interface and `montgomery` core instances; the multiplier itself is external.

Parameters:
- WORD_LEN, 512, operand/result width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- port1_din  in  32  command word; only bits [2:0] are decoded.
- port1_valid  in  1  host presents a command.
- port1_read  out  1  one-cycle pulse: command accepted.
- port2_valid  out  1  command complete; held until port2_read.
- port2_read  in  1  host acknowledges completion.
- bram_din  in  WORD_LEN  operand word from BRAM.
- bram_din_valid  in  1  bram_din valid this cycle.
- bram_dout  out  WORD_LEN  result word to BRAM.
- bram_dout_valid  out  1  bram_dout valid; held until bram_dout_read.
- bram_dout_read  in  1  BRAM side consumed bram_dout.
- mult_a, mult_b, mult_m  out  WORD_LEN each  operand registers to the core.
- mult_start  out  1  one-cycle start pulse.
- mult_done  in  1  core result valid (pulse or level).
- mult_result  in  WORD_LEN  core result.
- leds  out  4  {err_flag, state[2:0]}.

Behaviour:
- Reset (asynchronous): all outputs 0, all registers 0, state = IDLE.
- Opcodes (port1_din[2:0]):
  - 0 READ_A, 1 READ_B, 2 READ_M, 3 MULTIPLY, 4 WRITE.
  - 5-7 are illegal.
- IDLE: if port1_valid=1, latch opcode, go to ACCEPT.
- ACCEPT: port1_read=1 for exactly this cycle.
  - Opcode 0-2 -> LOAD; 3 -> START; 4 -> WRITE; 5-7 -> DONE with err_flag set.
- LOAD: wait for bram_din_valid=1, then capture bram_din into the A, B or M register, go to DONE.
  - Words arriving in any other state are dropped.
- START: mult_start=1 for one cycle, go to BUSY.
- BUSY: on mult_done=1, capture mult_result into the result register, go to DONE.
- WRITE:
  - Drive bram_dout = result register and bram_dout_valid=1.
  - On bram_dout_read=1, deassert bram_dout_valid next cycle, go to DONE.
- DONE:
  - port2_valid=1, held until port2_read=1 is sampled; then port2_valid=0 next cycle and state -> IDLE.
  - err_flag is cleared on the next legal command's ACCEPT.
- Handshake rules:
  - port1_valid is ignored outside IDLE.
  - The host must drop port1_valid after seeing port1_read; a command still asserted when IDLE is re-entered is treated as a new command.
- Timing and conditions:
  - Minimum command-to-port2_valid latency: 3 cycles (ACCEPT, one state, DONE) for a load with bram_din_valid already high.
  - WRITE before any MULTIPLY returns 0.
  - MULTIPLY uses the operand registers as they stand (no check that A, B, M were loaded).
  - bram_din_valid and bram_dout_read may be held high across cycles; only the first qualifying edge in the waiting state counts.
  - mult_a/b/m are stable from START until the next load.
- Reset mid-operation: immediate return to IDLE, outputs 0, operands cleared; a pending core computation is abandoned and a late mult_done in IDLE is ignored.
- leds[2:0] encoding: IDLE=0, ACCEPT=1, LOAD=2, START=3, BUSY=4, WRITE=5, DONE=6.

Test Plan:
- Cmd 0 followed by bram_din=512'h5 (valid for 1 cycle) -> port1_read pulses once; mult_a=5; port2_valid rises, held until port2_read, then clears.
- Cmds 1 and 2 with 512'h7 and 512'hB, then cmd 3; core model asserts mult_done after 10 cycles with result 512'h9 -> exactly one mult_start pulse; port2_valid after mult_done.
- Cmd 4 -> bram_dout=512'h9 with bram_dout_valid high; delay bram_dout_read by 5 cycles -> data held stable, port2_valid only after the read.
- Cmd 7 -> port1_read pulses, leds[3]=1, port2_valid; next cmd 0 clears leds[3].
- Raise bram_din_valid while in IDLE, then issue cmd 0 with a second word 512'h3 -> mult_a=3 (first word dropped).
- Assert reset during BUSY, then pulse mult_done -> all outputs 0, state stays IDLE, no port2_valid.
